// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial front end for the serial pattern-detector stage.
//   WIDTH-bit words are taken on a valid/ready handshake and sent out one bit
//   per clk. dout is held at 0 between words so the detector always sees a
//   defined stream.
//
// Configuration macro:
//   BIT_SERIALIZER_PARITY_EN  - when defined, an even-parity bit (^word) is
//                               appended after the last data bit (PAR state),
//                               so each word costs WIDTH+1 clks instead of
//                               WIDTH clks.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes first, 0: bit 0 goes first
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   din         parallel word, sampled when din_valid & din_ready
//   din_valid   upstream has a word on din
//   din_ready   word accepted this cycle (combinational from state/counter)
//   dout        serial bit, 0 whenever dout_valid is 0 (registered)
//   dout_valid  dout carries a data or parity bit (registered)
//   busy        a word is in flight, state != IDLE (registered)
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ZERO = CW'(0);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam logic [CW-1:0] PCNT = CW'(WIDTH);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_word_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_dout;
  logic             w_dout_nxt;
  logic             r_dout_valid;
  logic             w_dout_valid_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_ready;
  logic             w_accept;

  // Bit number `c` of the transmit order; the word register is never shifted,
  // the counter selects the bit instead, so the word stays intact for parity.
  function automatic logic word_bit(input logic [WIDTH-1:0] w,
                                    input logic [CW-1:0]    c);
    logic [CW-1:0] idx;
    logic          b;
    idx = MSB_FIRST ? (LAST - c) : c;
    b   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == idx) begin
        b = w[i];
      end
    end
    return b;
  endfunction

`ifdef BIT_SERIALIZER_PARITY_EN
  // Even parity over the whole word.
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  assign din_ready  = w_ready;
  assign w_accept   = din_valid & w_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;

  // Ready decode: depends only on reset, state and counter, never on din_valid.
  always_comb begin
    w_ready = 1'b0;
    if (reset) begin
      w_ready = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:  w_ready = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        ST_SHIFT: w_ready = 1'b0;
        ST_PAR:   w_ready = 1'b1;
`else
        ST_SHIFT: w_ready = (r_cnt == LAST);
        ST_PAR:   w_ready = 1'b0;
`endif
        default:  w_ready = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SHIFT;
        else          w_state_nxt = ST_IDLE;
      end
      ST_SHIFT: begin
        if (r_cnt != LAST) begin
          w_state_nxt = ST_SHIFT;
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          if (w_accept) w_state_nxt = ST_SHIFT;
          else          w_state_nxt = ST_IDLE;
`endif
        end
      end
      ST_PAR: begin
`ifdef BIT_SERIALIZER_PARITY_EN
        if (w_accept) w_state_nxt = ST_SHIFT;
        else          w_state_nxt = ST_IDLE;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values. The first bit of an accepted word is
  // computed from din directly so it appears one clk after the accept edge.
  always_comb begin
    w_word_nxt       = r_word;
    w_cnt_nxt        = r_cnt;
    w_dout_nxt       = 1'b0;
    w_dout_valid_nxt = 1'b0;
    if (w_accept) begin
      w_word_nxt       = din;
      w_cnt_nxt        = ZERO;
      w_dout_nxt       = word_bit(din, ZERO);
      w_dout_valid_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (r_cnt != LAST) begin
            w_cnt_nxt        = r_cnt + ONE;
            w_dout_nxt       = word_bit(r_word, r_cnt + ONE);
            w_dout_valid_nxt = 1'b1;
          end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
            w_cnt_nxt        = PCNT;
            w_dout_nxt       = even_parity(r_word);
            w_dout_valid_nxt = 1'b1;
`else
            w_cnt_nxt        = ZERO;
            w_dout_nxt       = 1'b0;
            w_dout_valid_nxt = 1'b0;
`endif
          end
        end
        ST_PAR: begin
          w_cnt_nxt        = ZERO;
          w_dout_nxt       = 1'b0;
          w_dout_valid_nxt = 1'b0;
        end
        ST_IDLE: begin
          w_cnt_nxt        = ZERO;
          w_dout_nxt       = 1'b0;
          w_dout_valid_nxt = 1'b0;
        end
        default: begin
          w_cnt_nxt        = ZERO;
          w_dout_nxt       = 1'b0;
          w_dout_valid_nxt = 1'b0;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word       <= {WIDTH{1'b0}};
      r_cnt        <= ZERO;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_word       <= w_word_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Directed bench for bit_serializer. Two instances share clk/reset: u_dut
//   (MSB first) and u_lsb (MSB_FIRST=0). Inputs change and outputs are checked
//   1 time unit after each rising edge; "cycle n" is the interval after edge n.
//   Honours BIT_SERIALIZER_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din, din2;
  logic       din_valid, din_valid2;
  logic       din_ready, din_ready2;
  logic       dout, dout2;
  logic       dout_valid, dout_valid2;
  logic       busy, busy2;

  int n_vec = 0;
  int n_err = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din2), .din_valid(din_valid2),
    .din_ready(din_ready2), .dout(dout2), .dout_valid(dout_valid2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the 8 data bits (MSB first) of word w on u_dut, then the parity bit
  // if enabled. Called in cycle 1 of the word; returns one cycle after the
  // last bit (or the parity bit).
  task automatic check_bits(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bit%0d", i), {7'd0, dout}, {7'd0, w[7-i]});
      chk($sformatf("dval%0d", i), {7'd0, dout_valid}, 8'd1);
      chk($sformatf("busy%0d", i), {7'd0, busy}, 8'd1);
      chk($sformatf("rdy%0d", i), {7'd0, din_ready}, {7'd0, (i == 7) && !PAR});
      tick();
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    chk("par_bit", {7'd0, dout}, {7'd0, ^w});
    chk("par_dval", {7'd0, dout_valid}, 8'd1);
    chk("par_rdy", {7'd0, din_ready}, 8'd1);
    tick();
`endif
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_dout"}, {7'd0, dout}, 8'd0);
    chk({tag, "_dval"}, {7'd0, dout_valid}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_rdy"}, {7'd0, din_ready}, 8'd1);
  endtask

  initial begin
    reset      = 1'b1;
    din        = 8'h00;
    din_valid  = 1'b0;
    din2       = 8'h00;
    din_valid2 = 1'b0;
    #1;
    tick();
    // Reset state, with din_valid high to show nothing is accepted.
    din_valid = 1'b1;
    din       = 8'hFF;
    tick();
    chk("rst_rdy", {7'd0, din_ready}, 8'd0);
    chk("rst_dout", {7'd0, dout}, 8'd0);
    chk("rst_dval", {7'd0, dout_valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    din_valid = 1'b0;
    reset     = 1'b0;
    #1;
    check_idle("post_rst");

    // Single word 0xCC, din changes while ready is low.
    din       = 8'hCC;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = 8'h5A;
    check_bits(8'hCC);
    check_idle("cc_end");

    // Back-to-back 0xCC then 0x33 with din_valid held.
    din       = 8'hCC;
    din_valid = 1'b1;
    chk("b2b_rdy0", {7'd0, din_ready}, 8'd1);
    tick();
    din = 8'h33;
    check_bits(8'hCC);
    din_valid = 1'b0;
    check_bits(8'h33);
    check_idle("b2b_end");

    // Stall: 5 idle cycles, no spurious bits.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle($sformatf("stall%0d", i));
    end

    // LSB-first instance, 0x01.
    din2       = 8'h01;
    din_valid2 = 1'b1;
    tick();
    din_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb_bit%0d", i), {7'd0, dout2}, {7'd0, (i == 0)});
      chk($sformatf("lsb_busy%0d", i), {7'd0, busy2}, 8'd1);
      tick();
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    chk("lsb_par", {7'd0, dout2}, 8'd1);
    chk("lsb_par_dval", {7'd0, dout_valid2}, 8'd1);
    tick();
`endif
    chk("lsb_end_busy", {7'd0, busy2}, 8'd0);
    chk("lsb_end_dval", {7'd0, dout_valid2}, 8'd0);

    // Reset pulse mid-word (bit 3 of 0xFF) acts asynchronously.
    din       = 8'hFF;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    chk("mid_bit3", {7'd0, dout}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_dout", {7'd0, dout}, 8'd0);
    chk("async_dval", {7'd0, dout_valid}, 8'd0);
    chk("async_busy", {7'd0, busy}, 8'd0);
    chk("async_rdy", {7'd0, din_ready}, 8'd0);
    tick();
    reset = 1'b0;
    #1;
    check_idle("rel");

    // Clean restart with 0xA5.
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check_bits(8'hA5);
    check_idle("a5_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
